// File: rtl/flappy_scroll_sequencer.sv
// -----------------------------------------------------------------------------
// flappy_scroll_sequencer
//
// Per-frame parallax scroll scheduler for the FlappySpace background.
// At the first blanking line (vpos == V_ACTIVE, hpos == 0) each layer's
// unsigned 4.4 speed is added to a 4-bit fractional accumulator. The whole
// pixel part of the sum is then issued as single-step advance requests to
// that layer's seed generator, one layer after another. All advancing ends
// well inside vertical blanking, so active-area walks see a stable seed.
//
// Ports
//   clk          pixel clock
//   reset        asynchronous, active-low reset
//   hpos, vpos   current raster position from the sync generator
//   pause        when high at frame start, the whole frame is skipped
//   cfg_we       speed register write strobe
//   cfg_addr     layer to write (addresses >= NUM_LAYERS are ignored)
//   cfg_data     speed, unsigned 4.4 pixels per frame
//   adv_valid    step request towards layer adv_layer
//   adv_layer    target layer of the current request
//   adv_ready    consumer accepts a step when adv_valid && adv_ready
//   busy         sequencer is working through a frame
//   frame_done   one-cycle pulse when the last layer has finished
//   frame_count  completed (non-skipped) frames, wraps 255 -> 0
//   overrun      sticky, a frame start arrived while still busy
// -----------------------------------------------------------------------------
module flappy_scroll_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int LW         = 2,
    parameter int V_ACTIVE   = 480
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    hpos,
    input  logic [9:0]    vpos,
    input  logic          pause,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [7:0]    cfg_data,
    output logic          adv_valid,
    output logic [LW-1:0] adv_layer,
    input  logic          adv_ready,
    output logic          busy,
    output logic          frame_done,
    output logic [7:0]    frame_count,
    output logic          overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_STEP  = 2'd2
    } state_t;

    localparam logic [7:0]    SPEED_RST = 8'h10;
    localparam logic [LW-1:0] LAST_IDX  = LW'(NUM_LAYERS - 1);

    // Speed plus carried fraction; the 9-bit result keeps the full 0..16
    // whole-pixel range (0xFF + 0xF = 0x10E) without dropping the top bit.
    function automatic logic [8:0] accumulate(input logic [7:0] spd,
                                              input logic [3:0] fr);
        return {1'b0, spd} + {5'b0, fr};
    endfunction

    state_t        state, state_nx;
    logic [LW-1:0] idx, idx_nx;
    logic [4:0]    cnt, cnt_nx;
    logic          done_nx;
    logic          finish;

    logic [7:0]    speed [NUM_LAYERS];
    logic [3:0]    frac  [NUM_LAYERS];

    logic          frame_start;
    logic [8:0]    sum;
    logic          cfg_hit;

    assign frame_start = (vpos == 10'(V_ACTIVE)) && (hpos == 10'd0);
    assign sum         = accumulate(speed[idx], frac[idx]);
    assign cfg_hit     = cfg_we && ({29'd0, cfg_addr} < 32'(NUM_LAYERS));

    // Outputs are decoded from registered state only, so they move on edges.
    assign adv_valid = (state == S_STEP);
    assign adv_layer = idx;
    assign busy      = (state != S_IDLE);

    // ---- next-state / sequencing ----
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        finish   = 1'b0;

        case (state)
            S_IDLE: begin
                if (frame_start && !pause) begin
                    idx_nx   = '0;
                    state_nx = S_ACCUM;
                end
            end
            S_ACCUM: begin
                cnt_nx = sum[8:4];
                if (sum[8:4] == 5'd0) begin
                    finish = 1'b1;
                end else begin
                    state_nx = S_STEP;
                end
            end
            S_STEP: begin
                if (adv_ready) begin
                    cnt_nx = cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        finish = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (finish) begin
            if (idx == LAST_IDX) begin
                state_nx = S_IDLE;
                done_nx  = 1'b1;
            end else begin
                idx_nx   = idx + 1'b1;
                state_nx = S_ACCUM;
            end
        end
    end

    // ---- control registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            overrun     <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            frame_done <= done_nx;
            if (done_nx) begin
                frame_count <= frame_count + 8'd1;
            end
            // A frame start landing while a sequence is in flight is dropped.
            if (frame_start && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // ---- per-layer speed and fraction registers ----
    // ACCUM reads speed[idx] combinationally, so a same-cycle write to that
    // layer lands after the read and only affects the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                speed[i] <= SPEED_RST;
                frac[i]  <= 4'd0;
            end
        end else begin
            if (cfg_hit) begin
                speed[cfg_addr[LW-1:0]] <= cfg_data;
            end
            if (state == S_ACCUM) begin
                frac[idx] <= sum[3:0];
            end
        end
    end

endmodule

// File: tb/tb_flappy_scroll_sequencer.sv
module tb_flappy_scroll_sequencer;

    localparam int NL = 4;
    localparam int LW = 2;
    localparam int VA = 480;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    hpos, vpos;
    logic          pause;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [7:0]    cfg_data;
    logic          adv_valid;
    logic [LW-1:0] adv_layer;
    logic          adv_ready;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_count;
    logic          overrun;

    flappy_scroll_sequencer #(.NUM_LAYERS(NL), .LW(LW), .V_ACTIVE(VA)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .pause(pause),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .adv_valid(adv_valid), .adv_layer(adv_layer), .adv_ready(adv_ready),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: speeds, fractional remainders, completed frames.
    int speed_m [NL];
    int frac_m  [NL];
    int fc_m;
    int got_last [NL];
    int last_done_k;

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            speed_m[i] = 16;
            frac_m[i]  = 0;
        end
        fc_m = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = 3'(addr);
        cfg_data = 8'(data);
        tick();
        cfg_we = 1'b0;
        if (addr < NL) speed_m[addr] = data;
    endtask

    // Runs one frame from frame_start and checks per-layer step counts,
    // ordering, stall stability, latency and the frame counter.
    task automatic run_frame(input int ready_pct, input int stall_from, input bit do_pause,
                             input int wr_k, input int wr_layer, input int wr_data,
                             input string name);
        int exp_n [NL];
        int exp_total;
        int done_k;
        bit prev_stall;
        bit bad_valid;
        logic [LW-1:0] stall_layer;

        exp_total   = 1;
        done_k      = -1;
        prev_stall  = 1'b0;
        bad_valid   = 1'b0;
        stall_layer = '0;
        for (int i = 0; i < NL; i++) begin
            got_last[i] = 0;
            if (do_pause) begin
                exp_n[i] = 0;
            end else begin
                exp_n[i]  = (speed_m[i] + frac_m[i]) / 16;
                frac_m[i] = (speed_m[i] + frac_m[i]) % 16;
            end
            exp_total += 1 + exp_n[i];
        end

        vpos      = 10'(VA);
        hpos      = 10'd0;
        pause     = do_pause;
        adv_ready = ($urandom_range(0, 99) < ready_pct);

        for (int k = 1; k <= 3000; k++) begin
            tick();
            cfg_we = 1'b0;
            if (k == 1) begin
                vpos  = 10'($urandom_range(0, VA - 1));
                hpos  = 10'($urandom_range(0, 799));
                pause = 1'b0;
            end
            if (prev_stall) begin
                tests++;
                if (adv_valid !== 1'b1 || adv_layer !== stall_layer) begin
                    fails++;
                    $display("FAIL %s stall_hold k=%0d: valid=%b layer=%0d, required valid=1 layer=%0d",
                             name, k, adv_valid, adv_layer, stall_layer);
                end
            end
            if (k == 2 && !do_pause) begin
                tests++;
                if (adv_valid !== (exp_n[0] > 0)) begin
                    fails++;
                    $display("FAIL %s first_valid_T+2: got %b, required %b", name, adv_valid, exp_n[0] > 0);
                end
            end
            if (adv_valid === 1'b1 && exp_n[adv_layer] == 0) bad_valid = 1'b1;
            if (frame_done === 1'b1) begin
                done_k = k;
                break;
            end
            if (do_pause && k >= 40) break;
            adv_ready = ($urandom_range(0, 99) < ready_pct);
            if (stall_from > 0 && k >= stall_from && k < stall_from + 5) adv_ready = 1'b0;
            if (k == wr_k) begin
                cfg_we   = 1'b1;
                cfg_addr = 3'(wr_layer);
                cfg_data = 8'(wr_data);
            end
            if (adv_valid === 1'b1 && adv_ready === 1'b1) got_last[adv_layer]++;
            prev_stall  = (adv_valid === 1'b1) && !adv_ready;
            stall_layer = adv_layer;
        end
        cfg_we = 1'b0;
        last_done_k = done_k;
        if (!do_pause && wr_k > 0 && wr_layer < NL) speed_m[wr_layer] = wr_data;

        tests++;
        if (bad_valid) begin
            fails++;
            $display("FAIL %s valid_on_zero_layer: adv_valid seen for a layer with 0 steps", name);
        end
        if (do_pause) begin
            tests++;
            if (done_k != -1) begin
                fails++;
                $display("FAIL %s pause_done: frame_done at k=%0d, required none", name, done_k);
            end
            tests++;
            if (frame_count !== 8'(fc_m)) begin
                fails++;
                $display("FAIL %s pause_count: got %0d, required %0d", name, frame_count, fc_m);
            end
        end else begin
            fc_m = (fc_m + 1) % 256;
            tests++;
            if (done_k < 0) begin
                fails++;
                $display("FAIL %s done_timeout: no frame_done within budget", name);
            end
            for (int i = 0; i < NL; i++) begin
                tests++;
                if (got_last[i] != exp_n[i]) begin
                    fails++;
                    $display("FAIL %s steps_layer%0d: got %0d, required %0d", name, i, got_last[i], exp_n[i]);
                end
            end
            tests++;
            if (frame_count !== 8'(fc_m)) begin
                fails++;
                $display("FAIL %s frame_count: got %0d, required %0d", name, frame_count, fc_m);
            end
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL %s busy_at_done: got %b, required 0", name, busy);
            end
            if (ready_pct == 100 && stall_from == 0) begin
                tests++;
                if (done_k != exp_total) begin
                    fails++;
                    $display("FAIL %s done_latency: got T+%0d, required T+%0d", name, done_k, exp_total);
                end
            end
            tick();
            tests++;
            if (frame_done !== 1'b0) begin
                fails++;
                $display("FAIL %s done_pulse_width: got %b, required 0", name, frame_done);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (adv_valid !== 1'b0 || adv_layer !== '0 || busy !== 1'b0 || frame_done !== 1'b0 ||
            frame_count !== 8'd0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL %s: valid=%b layer=%0d busy=%b done=%b count=%0d overrun=%b, required all 0",
                     name, adv_valid, adv_layer, busy, frame_done, frame_count, overrun);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        hpos = 10'd0; vpos = 10'd0; pause = 1'b0;
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0; adv_ready = 1'b1;
        model_reset();
        tick();
        tick();
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_default_frame();
        run_frame(100, 0, 1'b0, 0, 0, 0, "default");
        tests++;
        if (last_done_k != 9) begin
            fails++;
            $display("FAIL default_T+9: frame_done at T+%0d, required T+9", last_done_k);
        end
    endtask

    task automatic test_fractional();
        cfg_write(1, 8'h18);
        for (int f = 0; f < 4; f++) begin
            run_frame(100, 0, 1'b0, 0, 0, 0, "frac_1p5");
            tests++;
            if (got_last[1] != ((f % 2 == 0) ? 1 : 2)) begin
                fails++;
                $display("FAIL frac_1p5_pattern frame %0d: got %0d, required %0d", f, got_last[1], (f % 2 == 0) ? 1 : 2);
            end
        end
    endtask

    task automatic test_max_count();
        cfg_write(2, 8'h0F);
        run_frame(100, 0, 1'b0, 0, 0, 0, "frac15_setup");
        cfg_write(2, 8'hFF);
        run_frame(100, 0, 1'b0, 0, 0, 0, "max16");
        tests++;
        if (got_last[2] != 16) begin
            fails++;
            $display("FAIL max16_layer2: got %0d steps, required 16", got_last[2]);
        end
    endtask

    task automatic test_stall();
        cfg_write(0, 8'h40);
        run_frame(100, 3, 1'b0, 0, 0, 0, "stall5");
    endtask

    task automatic test_cfg_during_accum();
        for (int i = 0; i < NL; i++) cfg_write(i, 8'h10);
        // Layer 1 ACCUM is cycle T+3 when every layer makes exactly one step.
        run_frame(100, 0, 1'b0, 3, 1, 8'h30, "wr_in_accum");
        run_frame(100, 0, 1'b0, 0, 0, 0, "wr_next_frame");
    endtask

    task automatic test_invalid_addr();
        for (int a = NL; a < 8; a++) cfg_write(a, $urandom_range(0, 255));
        cfg_write(3, 8'h24);
        run_frame(100, 0, 1'b0, 0, 0, 0, "invalid_addr");
    endtask

    task automatic test_pause();
        run_frame(100, 0, 1'b1, 0, 0, 0, "pause");
        run_frame(100, 0, 1'b0, 0, 0, 0, "after_pause");
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < NL; i++)
                cfg_write(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255));
            run_frame(60, 0, 1'b0, 0, 0, 0, "random");
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < NL; i++) cfg_write(i, 0);
        for (int f = 0; f < 256; f++) begin
            run_frame(100, 0, 1'b0, 0, 0, 0, "wrap");
            if (fc_m == 0) break;
        end
        tests++;
        if (frame_count !== 8'd0) begin
            fails++;
            $display("FAIL wrap_to_zero: got %0d, required 0", frame_count);
        end
        run_frame(100, 0, 1'b0, 0, 0, 0, "after_wrap");
    endtask

    task automatic test_overrun_reset();
        cfg_write(0, 8'h80);
        adv_ready = 1'b0;
        vpos = 10'(VA); hpos = 10'd0;
        tick();
        vpos = 10'd0; hpos = 10'd5;
        tick();
        tick();
        tests++;
        if (adv_valid !== 1'b1 || busy !== 1'b1 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_pre: valid=%b busy=%b overrun=%b, required 1 1 0", adv_valid, busy, overrun);
        end
        vpos = 10'(VA); hpos = 10'd0;
        tick();
        vpos = 10'd0; hpos = 10'd5;
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: got %b, required 1", overrun);
        end
        for (int k = 0; k < 5; k++) tick();
        tests++;
        if (overrun !== 1'b1 || adv_valid !== 1'b1 || adv_layer !== '0) begin
            fails++;
            $display("FAIL overrun_sticky: overrun=%b valid=%b layer=%0d, required 1 1 0", overrun, adv_valid, adv_layer);
        end
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid_step");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        adv_ready = 1'b1;
        tick();
        run_frame(100, 0, 1'b0, 0, 0, 0, "post_reset_default");
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_fractional();
        test_max_count();
        test_stall();
        test_cfg_during_accum();
        test_invalid_addr();
        test_pause();
        test_random();
        test_wrap();
        test_overrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flappy_scroll_sequencer.md
# flappy_scroll_sequencer

Per-frame parallax scroll scheduler for the FlappySpace background. Once per frame, at entry to vertical blanking, it adds each layer's programmable fractional speed to a per-layer accumulator. It then issues the resulting whole-pixel count as single-step advance requests to that layer's seed LFSR/mountain generator, layer by layer, over a valid/ready handshake. All advancing completes inside vertical blanking, so the active-area LFSR walks see a stable seed.

## Interface
- NUM_LAYERS, 4, number of scrolled layers (2..8)
- LW, 2, layer index width, equals clog2(NUM_LAYERS)
- V_ACTIVE, 480, first blanking line; a frame starts at vpos==V_ACTIVE && hpos==0
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hpos  in  10  current pixel column from VgaSyncGen
- vpos  in  10  current line from VgaSyncGen
- pause  in  1  when high at frame start, that frame is skipped
- cfg_we  in  1  speed register write strobe
- cfg_addr  in  3  layer to write; writes with cfg_addr >= NUM_LAYERS are ignored
- cfg_data  in  8  speed, unsigned 4.4 fixed point (pixels per frame)
- adv_valid  out  1  step request to layer adv_layer
- adv_layer  out  LW  target layer of the current request
- adv_ready  in  1  consumer accepts a step on adv_valid && adv_ready
- busy  out  1  FSM not in IDLE
- frame_done  out  1  one-cycle pulse when the last layer finishes
- frame_count  out  8  completed (non-skipped) frames, wraps 255->0
- overrun  out  1  sticky; set when a frame start arrives while busy

## Operation
- Per-layer state:
  - speed[i]: 8 bits; reset value 8'h10 (1.0 px/frame).
  - frac[i]: 4 bits; reset value 0.
- frame_start is combinational: (vpos==V_ACTIVE) && (hpos==0). It is true for exactly one cycle per frame.
- FSM states: IDLE, ACCUM, STEP.
- IDLE:
  - On frame_start && !pause: idx<=0, go to ACCUM.
  - On frame_start && pause: stay in IDLE. frac, frame_count and outputs are unchanged.
- ACCUM (one cycle):
  - sum = {1'b0,speed[idx]} + {5'b0,frac[idx]} (9 bits).
  - frac[idx] <= sum[3:0].
  - cnt <= sum[8:4], range 0..16.
  - If sum[8:4]==0, finish the layer (see below). Otherwise go to STEP.
- STEP:
  - adv_valid=1, adv_layer=idx.
  - On each cycle with adv_ready=1, cnt decrements.
  - When the accepted step had cnt==1, finish the layer.
  - adv_valid stays high while adv_ready is low. There is no timeout.
- Finish layer:
  - If idx==NUM_LAYERS-1: go to IDLE, pulse frame_done, increment frame_count.
  - Otherwise: idx<=idx+1, go to ACCUM.
- frame_start while busy: the event is ignored, overrun<=1, and the current sequence continues unaffected. overrun clears only on reset.
- Config writes:
  - Accepted in any state; speed[cfg_addr]<=cfg_data.
  - A write to layer idx in the same cycle as its ACCUM: ACCUM uses the old value and the new value applies next frame.
- Speed 0 yields no steps and no adv_valid for that layer. The fractional remainder is kept (0 + frac stays below 1).
- Reset (asserted low, any time, including mid-STEP):
  - FSM goes to IDLE, idx=0, cnt=0.
  - adv_valid=0, adv_layer=0, busy=0, frame_done=0, frame_count=0, overrun=0.
  - All speed registers return to 8'h10 and all frac to 0.

## Timing
- frame_start is in cycle T. ACCUM for layer 0 is in T+1. The first adv_valid is in T+2.
- adv_valid and adv_layer are registered (state-decoded). They change only on clk edges.
- A layer with n steps and adv_ready tied high occupies 1+n cycles. A layer with n=0 occupies 1 cycle.
- Worst case with ready tied high is NUM_LAYERS*17 cycles (68 for 4 layers). This is far below one blanking line, so there is no overrun at nominal VGA timing.
- frame_done is asserted in the cycle after the last accepted step (or after the last ACCUM when that layer's n=0), coincident with busy falling.
- frame_count updates on the same edge that raises frame_done.

## Test plan
- Reset defaults, adv_ready=1, run one frame: layer 0 gets 1 step, then layers 1, 2 and 3 each get 1 step. frame_done arrives at T+9. frame_count=1.
- Layer 1 speed=8'h18 (1.5 px/frame) over 4 frames: layer 1 step counts are 1, 2, 1, 2, and frac alternates 8 then 0.
- Layer 2 speed=8'hFF with frac=15 from a previous frame: sum=0x10E, giving 16 steps. Check that no bits are dropped in the 5-bit count.
- adv_ready low for 5 cycles mid-STEP: adv_valid and adv_layer hold steady, and the total accepted steps still equal the computed count.
- pause high at frame start: no adv_valid, no frame_done, frame_count unchanged, frac unchanged.
- Hold adv_ready low across the next frame_start: overrun=1 and stays 1. Then assert reset mid-STEP: adv_valid drops immediately, and all outputs return to the reset values listed under Operation.
